// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit scheduler and its arbiter.
// Holds the serializer state encoding, frame data width and an ID-width helper.
// No logic of its own.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int UART_DATA_W = 8;

  // Width of an index over n items, never less than one bit
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/uart_rr_arbiter.sv
// Round-robin pick among byte requesters, scanning upward from the pointer.
// Grant is combinational; the pointer moves on the clock edge of a transfer.
// No backpressure of its own; the caller qualifies the grant with its accept window.
module uart_rr_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic [N_REQ-1:0]          valid,
  input  logic                      advance,
  output logic [N_REQ-1:0]          gnt,
  output logic [clog2(N_REQ)-1:0]   winner
);

  localparam int ID_W = clog2(N_REQ);
  localparam int SW   = ID_W + 1;

  logic [ID_W-1:0] ptr;
  logic [SW-1:0]   sum;
  logic [ID_W-1:0] idx;

  // Walk from the highest offset down so the lowest offset (closest to ptr) wins
  always_comb begin
    gnt    = '0;
    winner = '0;
    sum    = '0;
    idx    = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      sum = {1'b0, ptr} + SW'(i);
      if (sum >= SW'(N_REQ)) sum = sum - SW'(N_REQ);
      idx = sum[ID_W-1:0];
      if (valid[idx]) begin
        gnt      = '0;
        gnt[idx] = 1'b1;
        winner   = idx;
      end
    end
  end

  // Move the pointer just past the requester that was served
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (winner == ID_W'(N_REQ - 1)) ? '0 : winner + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Shares one 8N1 UART transmit line between N_REQ byte sources, round-robin.
// Frame starts on the baud tick of acceptance and lasts 1+8+STOP_BITS tick periods.
// o_ready only opens on a tick while idle or in the last stop bit; others hold valid.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = UART_DATA_W,
  parameter int STOP_BITS = 1
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_baud_tick,
  input  logic [N_REQ-1:0]          i_valid,
  input  logic [N_REQ*DATA_W-1:0]   i_data,
  output logic [N_REQ-1:0]          o_ready,
  output logic                      o_tx,
  output logic                      o_busy,
  output logic [clog2(N_REQ)-1:0]   o_gnt_id,
  output logic                      o_frame_done
);

  localparam int         ID_W      = clog2(N_REQ);
  localparam logic       STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic [2:0] LAST_BIT  = 3'(DATA_W - 1);

  tx_state_t         state;
  logic [DATA_W-1:0] shreg;
  logic [2:0]        bit_cnt;
  logic              stop_cnt;
  logic              window;
  logic              xfer;
  logic [N_REQ-1:0]  gnt;
  logic [ID_W-1:0]   winner;
  logic [DATA_W-1:0] win_byte;

  // A new byte may only be taken on a tick when the line is free for a start bit
  assign window   = i_reset & i_baud_tick &
                    ((state == IDLE) | ((state == STOP) & (stop_cnt == STOP_LAST)));
  assign o_ready  = gnt & {N_REQ{window}};
  assign xfer     = |(i_valid & o_ready);
  assign win_byte = i_data[int'(winner)*DATA_W +: DATA_W];

  uart_rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_arb (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .valid   (i_valid),
    .advance (xfer),
    .gnt     (gnt),
    .winner  (winner)
  );

  // Serializer: all line changes land on baud-tick edges; frame_done self-clears
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state        <= IDLE;
      shreg        <= '0;
      bit_cnt      <= '0;
      stop_cnt     <= 1'b0;
      o_tx         <= 1'b1;
      o_busy       <= 1'b0;
      o_gnt_id     <= '0;
      o_frame_done <= 1'b0;
    end else begin
      o_frame_done <= 1'b0;
      if (i_baud_tick) begin
        case (state)
          IDLE: begin
            if (xfer) begin
              shreg    <= win_byte;
              o_tx     <= 1'b0;
              bit_cnt  <= '0;
              o_busy   <= 1'b1;
              o_gnt_id <= winner;
              state    <= START;
            end
          end
          START: begin
            o_tx  <= shreg[0];
            state <= DATA;
          end
          DATA: begin
            if (bit_cnt != LAST_BIT) begin
              shreg   <= shreg >> 1;
              o_tx    <= shreg[1];
              bit_cnt <= bit_cnt + 1'b1;
            end else begin
              o_tx     <= 1'b1;
              stop_cnt <= 1'b0;
              state    <= STOP;
            end
          end
          STOP: begin
            if (stop_cnt != STOP_LAST) begin
              stop_cnt <= stop_cnt + 1'b1;
            end else begin
              o_frame_done <= 1'b1;
              if (xfer) begin
                // Back-to-back frame: start bit follows the stop bit directly
                shreg    <= win_byte;
                o_tx     <= 1'b0;
                bit_cnt  <= '0;
                o_gnt_id <= winner;
                state    <= START;
              end else begin
                o_busy <= 1'b0;
                state  <= IDLE;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: a frame decoder checks every frame on the line against a
// queue of expected {requester, byte} pairs; a vector table covers arbitration, and
// hand-written sequences cover back-to-back, late request, two stop bits and reset.
module tb_uart_tx_sched;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] dat;
  } frame_t;

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] data;
    logic [1:0]  exp_id;
    logic [7:0]  exp_byte;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        tick;
  logic [3:0]  v1, v2, rdy1, rdy2;
  logic [31:0] d1, d2;
  logic        tx1, tx2, busy1, busy2, done1, done2;
  logic [1:0]  gnt1, gnt2;

  int     checks = 0;
  int     errors = 0;
  int     tcnt = 0;
  int     n_push = 0;
  logic   edge_tick = 1'b0;
  frame_t sb_q[$];
  vec_t   vecs[5];

  // monitor state
  int     mst = 0;
  int     mbits_n = 0;
  int     b2b = 0;
  int     done_cnt = 0;
  logic   mon_t;
  logic [7:0] mbits;
  frame_t mexp;

  uart_tx_sched #(.N_REQ(4), .DATA_W(8), .STOP_BITS(1)) dut (
    .i_clk(clk), .i_reset(rst_n), .i_baud_tick(tick), .i_valid(v1), .i_data(d1),
    .o_ready(rdy1), .o_tx(tx1), .o_busy(busy1), .o_gnt_id(gnt1), .o_frame_done(done1)
  );

  uart_tx_sched #(.N_REQ(4), .DATA_W(8), .STOP_BITS(2)) dut2 (
    .i_clk(clk), .i_reset(rst_n), .i_baud_tick(tick), .i_valid(v2), .i_data(d2),
    .o_ready(rdy2), .o_tx(tx2), .o_busy(busy2), .o_gnt_id(gnt2), .o_frame_done(done2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One clock: returns 1 time unit after the edge, with the next tick value driven
  task automatic step();
    @(posedge clk);
    edge_tick = tick;
    #1;
    tcnt++;
    tick = ((tcnt % 4) == 0);
  endtask

  task automatic settle();
    #2;
  endtask

  // Advance to just after the next baud-tick edge
  task automatic next_tick();
    do step(); while (!edge_tick);
    settle();
  endtask

  task automatic wait_ready(output int edges);
    int cyc;
    cyc   = 0;
    edges = 0;
    settle();
    while (rdy1 == 4'b0 && cyc < 400) begin
      step();
      if (edge_tick) edges++;
      settle();
      cyc++;
    end
    chk("ready_seen", 32'(|rdy1), 32'd1);
    chk("ready_on_tick", 32'(tick), 32'd1);
  endtask

  task automatic xfer(input logic [1:0] id, input logic [7:0] b, input string nm,
                      output int edges);
    logic [3:0] oh;
    frame_t f;
    oh = 4'b0001 << id;
    wait_ready(edges);
    chk({nm, "_ready"}, 32'(rdy1), 32'(oh));
    f.id  = id;
    f.dat = b;
    sb_q.push_back(f);
    n_push++;
    step();
    settle();
  endtask

  task automatic wait_idle();
    int cyc;
    cyc = 0;
    while ((busy1 || mst != 0 || sb_q.size() != 0) && cyc < 2000) begin
      step();
      settle();
      cyc++;
    end
    chk("drain", {29'd0, busy1, mst != 0, sb_q.size() != 0}, 32'd0);
  endtask

  task automatic mon_start();
    chk("frame_queued", 32'(sb_q.size() != 0), 32'd1);
    if (sb_q.size() != 0) mexp = sb_q.pop_front();
    else mexp = '0;
    chk("gnt_id", 32'(gnt1), 32'(mexp.id));
    chk("busy_at_start", 32'(busy1), 32'd1);
    mbits_n = 0;
    mst     = 1;
  endtask

  // Frame decoder on requester line: samples the bit driven on each tick edge
  initial begin
    forever begin
      @(posedge clk);
      mon_t = tick;
      #2;
      if (done1) done_cnt++;
      if (!rst_n) begin
        mst = 0;
      end else if (mon_t) begin
        case (mst)
          0: if (!tx1) mon_start();
          1: begin
            mbits = {tx1, mbits[7:1]};
            mbits_n++;
            if (mbits_n == 8) mst = 2;
          end
          2: begin
            chk("stop_bit", 32'(tx1), 32'd1);
            chk("done_early", 32'(done1), 32'd0);
            mst = 3;
          end
          default: begin
            chk("frame_done", 32'(done1), 32'd1);
            chk("frame_byte", 32'(mbits), 32'(mexp.dat));
            if (!tx1) begin
              b2b++;
              mon_start();
            end else begin
              chk("busy_after_frame", 32'(busy1), 32'd0);
              mst = 0;
            end
          end
        endcase
      end
    end
  end

  initial begin
    int e, nb, dc, b0;
    logic [9:0] txv;

    vecs[0] = '{4'b1111, 32'h4433_2211, 2'd2, 8'h33};
    vecs[1] = '{4'b0011, 32'h0000_5AC3, 2'd0, 8'hC3};
    vecs[2] = '{4'b1001, 32'h8100_007E, 2'd3, 8'h81};
    vecs[3] = '{4'b0100, 32'h00F0_0000, 2'd2, 8'hF0};
    vecs[4] = '{4'b0110, 32'h0012_3400, 2'd1, 8'h34};

    // Reset state: ready stays low even with valid and tick present
    rst_n = 1'b0;
    tick  = 1'b1;
    v1 = 4'hF; v2 = 4'hF;
    d1 = '0;   d2 = '0;
    #12;
    chk("rst_tx", 32'(tx1), 32'd1);
    chk("rst_busy", 32'(busy1), 32'd0);
    chk("rst_gnt", 32'(gnt1), 32'd0);
    chk("rst_done", 32'(done1), 32'd0);
    chk("rst_ready", 32'(rdy1), 32'd0);
    chk("rst_ready2", 32'(rdy2), 32'd0);
    chk("rst_tx2", 32'(tx2), 32'd1);
    v1 = 4'h0; v2 = 4'h0;
    step();
    step();
    rst_n = 1'b1;
    step();
    settle();

    // Single byte A5 from requester 1
    d1 = 32'h0000_A500;
    v1 = 4'b0010;
    xfer(2'd1, 8'hA5, "single", e);
    txv = {tx1, 9'd0};
    do step(); while (!tick);
    settle();
    chk("single_ready_once", 32'(rdy1), 32'd0);
    v1 = 4'b0;
    nb = 1;
    while (nb < 20) begin
      next_tick();
      if (!busy1) break;
      if (nb < 10) txv = {tx1, txv[9:1]};
      nb++;
    end
    chk("single_busy_ticks", 32'(nb), 32'd10);
    chk("single_done", 32'(done1), 32'd1);
    chk("single_gnt", 32'(gnt1), 32'd1);
    chk("single_tx_seq", 32'(txv), 32'({1'b1, 8'hA5, 1'b0}));
    wait_idle();

    // Arbitration vectors, pointer carried from one to the next
    for (int i = 0; i < 5; i++) begin
      d1 = vecs[i].data;
      v1 = vecs[i].valid;
      xfer(vecs[i].exp_id, vecs[i].exp_byte, "vec", e);
      v1 = 4'b0;
      wait_idle();
    end

    // Reset while DATA bit 3 (a zero) is on the line
    d1 = 32'h0000_9600;
    v1 = 4'b0010;
    xfer(2'd1, 8'h96, "rst_pre", e);
    v1 = 4'b0;
    repeat (4) next_tick();
    chk("rst_line_low", 32'(tx1), 32'd0);
    dc = done_cnt;
    rst_n = 1'b0;
    v1 = 4'b1111;
    #1;
    chk("rst_mid_tx", 32'(tx1), 32'd1);
    chk("rst_mid_busy", 32'(busy1), 32'd0);
    chk("rst_mid_ready", 32'(rdy1), 32'd0);
    void'(sb_q.pop_front());
    n_push--;
    step();
    step();
    v1 = 4'b0;
    rst_n = 1'b1;
    settle();
    chk("post_rst_tx", 32'(tx1), 32'd1);
    chk("post_rst_gnt", 32'(gnt1), 32'd0);
    chk("post_rst_nodone", 32'(done_cnt), 32'(dc));
    // Pointer back at 0: requester 1 beats requester 3
    d1 = 32'h5B00_4400;
    v1 = 4'b1010;
    xfer(2'd1, 8'h44, "post_rst_ptr", e);
    v1 = 4'b0;
    wait_idle();
    v1 = 4'b1000;
    xfer(2'd3, 8'h5B, "post_rst_req3", e);
    v1 = 4'b0;
    wait_idle();

    // Round robin with all four held: 0,1,2,3,0 back to back
    d1 = 32'h0302_0100;
    v1 = 4'hF;
    b0 = b2b;
    for (int k = 0; k < 5; k++) xfer(2'(k % 4), 8'(k % 4), "rr", e);
    v1 = 4'b0;
    wait_idle();
    chk("rr_back_to_back", 32'(b2b - b0), 32'd4);

    // Late request during DATA waits for the final stop tick, then no gap
    d1 = 32'h00C9_003C;
    v1 = 4'b0001;
    xfer(2'd0, 8'h3C, "late0", e);
    v1 = 4'b0;
    repeat (3) next_tick();
    v1 = 4'b0100;
    b0 = b2b;
    xfer(2'd2, 8'hC9, "late2", e);
    chk("late_ready_tick", 32'(e), 32'd6);
    v1 = 4'b0;
    wait_idle();
    chk("late_back_to_back", 32'(b2b - b0), 32'd1);

    // Two stop bits: FF gives one low tick then ten high ticks
    d2 = 32'h0000_00FF;
    v2 = 4'b0001;
    nb = 0;
    settle();
    while (rdy2 == 4'b0 && nb < 400) begin
      step();
      settle();
      nb++;
    end
    chk("sb2_ready", 32'(rdy2), 32'd1);
    step();
    settle();
    v2 = 4'b0;
    chk("sb2_start", {29'd0, tx2, busy2, done2}, 32'b010);
    for (int k = 1; k <= 10; k++) begin
      next_tick();
      chk("sb2_high", {29'd0, tx2, busy2, done2}, 32'b110);
    end
    next_tick();
    chk("sb2_end", {29'd0, tx2, busy2, done2}, 32'b101);

    chk("done_pulses", 32'(done_cnt), 32'(n_push));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
